multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main control unit for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It waits on a memory ready handshake with a parametrised timeout and traps illegal opcodes and bus timeouts to an exception vector. It sits between the instruction register (Opcode source) and the shared-ALU, single-memory datapath muxes and enables.

## Interface
- MEM_TIMEOUT, 16: maximum wait cycles with MemReady low in any memory state before a bus-error trap; 0 disables the timeout.
- EXC_EN, 1: 1 routes illegal opcodes to TRAP; 0 treats them as NOPs (DECODE -> FETCH).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- Opcode  in  6  instruction bits [31:26], taken from the IR; stable from DECODE to end of instruction.
- MemReady  in  1  memory completes the current read or write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath enables and mux selects.
- PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 exception vector.
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded, 11 opcode-decoded (immediate ops).
- MemSize  out  2  00 byte, 01 half, 10 word.
- ExcValid  out  1  one-cycle pulse when a trap is taken.
- ExcCause  out  2  01 illegal opcode, 10 bus timeout; holds its last value between traps.
- State  out  4  current state encoding, for debug.

## Operation
- State encoding:
  - FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTE=6, RTYPEWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, TRAP=12
  - Encodings 13–15 are unreachable and go to FETCH.
- Outputs are decoded combinationally from State. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, MemSize=10.
  - IRWrite=PCWrite=MemReady, so the PC and IR update only on the ready cycle.
  - Stays in FETCH while MemReady=0; goes to DECODE on MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
  - 000000 -> EXECUTE.
  - 100011 lw, 100000 lb, 100001 lh, 101011 sw, 101000 sb, 101001 sh -> MEMADDR.
  - 000100 beq -> BRANCH.
  - 000010 j -> JUMP.
  - 001000 addi, 001100 andi, 001101 ori, 001010 slti -> IEXEC.
  - Any other opcode -> TRAP if EXC_EN=1, else FETCH.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMREAD if Opcode[3]=0, MEMWRITE if Opcode[3]=1.
- MEMREAD: MemRead=1, IorD=1. Waits for MemReady, then -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Waits for MemReady, then -> FETCH.
- MemSize in MEMADDR, MEMREAD and MEMWRITE comes from Opcode[1:0]: 00 -> 00, 01 -> 01, 11 -> 10.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> RTYPEWB.
- RTYPEWB: RegDst=1, RegWrite=1; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; -> FETCH.
- JUMP: PCWrite=1, PCSource=10; -> FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11; -> IWB.
- IWB: RegDst=0, RegWrite=1; -> FETCH.
- TRAP: PCWrite=1, PCSource=11, ExcValid=1. ExcCause is registered on entry. -> FETCH.
- Wait counter, width clog2(MEM_TIMEOUT+1):
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with MemReady=0.
  - Clears on any state change.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT with MemReady=0, the next state is TRAP with cause 10.
  - MemReady=1 in that same cycle wins: the transfer completes, no trap.

## Timing
- Reset:
  - While rst_n=0, State=FETCH, the wait counter is 0 and ExcCause=00.
  - All outputs are forced to 0 while rst_n=0.
  - The first cycle after release drives FETCH outputs.
- Reset asserted mid-instruction aborts immediately. No partial write-enable may persist after rst_n falls.
- Latency with MemReady tied high, FETCH through return to FETCH:
  - R-type 4, I-type 4, lw/lb/lh 5, sw/sb/sh 4, beq 3, j 3, trap 3 cycles.
- Each memory wait cycle adds 1 cycle.
- RegWrite, MemWrite and PCWrite are never asserted for more than one cycle per instruction.
- MemWrite is the exception: it stays high for every cycle of a MEMWRITE wait.

## Test plan
- Reset then R-type (Opcode 000000), MemReady=1 -> State sequence 0,1,6,7,0; RegWrite=1 only in state 7, with RegDst=1.
- lh (100001), MemReady low 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0; MemSize=01 in states 2–3; RegWrite=1 only in state 4.
- sb (101000), MemReady=1 -> states 0,1,2,5,0; MemWrite=1 for one cycle with MemSize=00; RegWrite never 1.
- Illegal opcode 111111:
  - EXC_EN=1 -> 0,1,12,0; ExcValid pulses once, ExcCause=01, PCSource=11.
  - EXC_EN=0 -> 0,1,0 with no pulse.
- MEM_TIMEOUT=4, MemReady held 0 in FETCH -> TRAP entered after 5 FETCH cycles, ExcCause=10.
  - Repeat with MemReady=1 on the 5th cycle -> DECODE, no trap.
- rst_n pulled low during MEMWRITE -> MemWrite drops to 0 asynchronously; after release State=0 and ExcCause=00.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle control unit and the datapath it steers.
// The controller drives the enables and mux selects. The datapath supplies
// the opcode from the IR and the memory ready handshake.
interface multicycle_control_if;
   logic [5:0] Opcode;
   logic       MemReady;

   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       IRWrite;
   logic       ALUSrcA;
   logic       RegWrite;
   logic       RegDst;
   logic [1:0] PCSource;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] MemSize;
   logic       ExcValid;
   logic [1:0] ExcCause;
   logic [3:0] State;

   modport master (
      input  Opcode, MemReady,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, MemSize,
             ExcValid, ExcCause, State
   );

   modport slave (
      output Opcode, MemReady,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, MemSize,
             ExcValid, ExcCause, State
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback. It waits on MemReady with a bounded timeout
// and traps illegal opcodes and bus timeouts to the exception vector.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter bit EXC_EN      = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master ctrl
);

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(MEM_TIMEOUT);
   localparam bit               TIMEOUT_ON = (MEM_TIMEOUT > 0);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_RTYPEWB  = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_IEXEC    = 4'd10,
      S_IWB      = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ILLEGAL = 2'b01,
      CAUSE_TIMEOUT = 2'b10
   } cause_t;

   state_t           state;
   state_t           next_state;
   cause_t           exc_cause;
   cause_t           trap_cause;
   logic [CNT_W-1:0] wait_cnt;
   logic             waiting;
   logic             timed_out;
   logic [1:0]       mem_size;

   // A cycle counts as a memory wait when a memory state sees no ready.
   always_comb begin
      waiting   = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE))
                  && !ctrl.MemReady;
      timed_out = TIMEOUT_ON && waiting && (wait_cnt == TIMEOUT);
   end

   // Next-state decode; a bus timeout overrides the normal transition.
   // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      next_state = S_FETCH;
      trap_cause = CAUSE_NONE;
      case (state)
         S_FETCH:    next_state = ctrl.MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (ctrl.Opcode)
               6'b000000:                       next_state = S_EXECUTE;
               6'b100011, 6'b100000, 6'b100001,
               6'b101011, 6'b101000, 6'b101001: next_state = S_MEMADDR;
               6'b000100:                       next_state = S_BRANCH;
               6'b000010:                       next_state = S_JUMP;
               6'b001000, 6'b001100,
               6'b001101, 6'b001010:            next_state = S_IEXEC;
               default: begin
                  if (EXC_EN) begin
                     next_state = S_TRAP;
                     trap_cause = CAUSE_ILLEGAL;
                  end else begin
                     next_state = S_FETCH;
                  end
               end
            endcase
         end
         S_MEMADDR:  next_state = ctrl.Opcode[3] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  next_state = ctrl.MemReady ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    next_state = S_FETCH;
         S_MEMWRITE: next_state = ctrl.MemReady ? S_FETCH : S_MEMWRITE;
         S_EXECUTE:  next_state = S_RTYPEWB;
         S_RTYPEWB:  next_state = S_FETCH;
         S_BRANCH:   next_state = S_FETCH;
         S_JUMP:     next_state = S_FETCH;
         S_IEXEC:    next_state = S_IWB;
         S_IWB:      next_state = S_FETCH;
         S_TRAP:     next_state = S_FETCH;
         default:    next_state = S_FETCH;
      endcase
      if (timed_out) begin
         next_state = S_TRAP;
         trap_cause = CAUSE_TIMEOUT;
      end
   end

   // State register, wait counter and trap cause capture.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         wait_cnt  <= '0;
         exc_cause <= CAUSE_NONE;
      end else begin
         state <= next_state;
         if (next_state != state) begin
            wait_cnt <= '0;
         end else if (waiting) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
         if (next_state == S_TRAP) begin
            exc_cause <= trap_cause;
         end
      end
   end

   // Access width from the low opcode bits: byte, half, otherwise word.
   always_comb begin
      case (ctrl.Opcode[1:0])
         2'b00:   mem_size = 2'b00;
         2'b01:   mem_size = 2'b01;
         default: mem_size = 2'b10;
      endcase
   end

   // Moore output decode, held at zero while reset is asserted.
   // NOTE: outputs are gated by rst_n so no enable survives the falling edge of reset, even combinationally.
   always_comb begin
      ctrl.PCWrite     = 1'b0;
      ctrl.PCWriteCond = 1'b0;
      ctrl.IorD        = 1'b0;
      ctrl.MemRead     = 1'b0;
      ctrl.MemWrite    = 1'b0;
      ctrl.MemtoReg    = 1'b0;
      ctrl.IRWrite     = 1'b0;
      ctrl.ALUSrcA     = 1'b0;
      ctrl.RegWrite    = 1'b0;
      ctrl.RegDst      = 1'b0;
      ctrl.PCSource    = 2'b00;
      ctrl.ALUSrcB     = 2'b00;
      ctrl.ALUOp       = 2'b00;
      ctrl.MemSize     = 2'b00;
      ctrl.ExcValid    = 1'b0;
      ctrl.ExcCause    = 2'b00;
      ctrl.State       = 4'd0;
      if (rst_n) begin
         ctrl.State    = state;
         ctrl.ExcCause = exc_cause;
         case (state)
            S_FETCH: begin
               ctrl.MemRead = 1'b1;
               ctrl.ALUSrcB = 2'b01;
               ctrl.MemSize = 2'b10;
               ctrl.IRWrite = ctrl.MemReady;
               ctrl.PCWrite = ctrl.MemReady;
            end
            S_DECODE: begin
               ctrl.ALUSrcB = 2'b11;
            end
            S_MEMADDR: begin
               ctrl.ALUSrcA = 1'b1;
               ctrl.ALUSrcB = 2'b10;
               ctrl.MemSize = mem_size;
            end
            S_MEMREAD: begin
               ctrl.MemRead = 1'b1;
               ctrl.IorD    = 1'b1;
               ctrl.MemSize = mem_size;
            end
            S_MEMWB: begin
               ctrl.MemtoReg = 1'b1;
               ctrl.RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
               ctrl.MemWrite = 1'b1;
               ctrl.IorD     = 1'b1;
               ctrl.MemSize  = mem_size;
            end
            S_EXECUTE: begin
               ctrl.ALUSrcA = 1'b1;
               ctrl.ALUOp   = 2'b10;
            end
            S_RTYPEWB: begin
               ctrl.RegDst   = 1'b1;
               ctrl.RegWrite = 1'b1;
            end
            S_BRANCH: begin
               ctrl.ALUSrcA     = 1'b1;
               ctrl.ALUOp       = 2'b01;
               ctrl.PCWriteCond = 1'b1;
               ctrl.PCSource    = 2'b01;
            end
            S_JUMP: begin
               ctrl.PCWrite  = 1'b1;
               ctrl.PCSource = 2'b10;
            end
            S_IEXEC: begin
               ctrl.ALUSrcA = 1'b1;
               ctrl.ALUSrcB = 2'b10;
               ctrl.ALUOp   = 2'b11;
            end
            S_IWB: begin
               ctrl.RegWrite = 1'b1;
            end
            S_TRAP: begin
               ctrl.PCWrite  = 1'b1;
               ctrl.PCSource = 2'b11;
               ctrl.ExcValid = 1'b1;
            end
            default: begin
               ctrl.MemSize = 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences, memory waits,
// bus timeout, illegal-opcode handling in both modes and asynchronous reset.
module tb_multicycle_control;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   multicycle_control_if bus_a ();
   multicycle_control_if bus_b ();

   multicycle_control #(.MEM_TIMEOUT(4), .EXC_EN(1'b1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus_a)
   );

   multicycle_control #(.MEM_TIMEOUT(16), .EXC_EN(1'b0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus_b)
   );

   wire [24:0] outs_a = {bus_a.PCWrite, bus_a.PCWriteCond, bus_a.IorD, bus_a.MemRead,
                         bus_a.MemWrite, bus_a.MemtoReg, bus_a.IRWrite, bus_a.ALUSrcA,
                         bus_a.RegWrite, bus_a.RegDst, bus_a.PCSource, bus_a.ALUSrcB,
                         bus_a.ALUOp, bus_a.MemSize, bus_a.ExcValid, bus_a.ExcCause,
                         bus_a.State};

   int n_run  = 0;
   int n_fail = 0;
   int cnt_regw;
   int cnt_memw;
   int cnt_exc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      cnt_regw = 0;
      cnt_memw = 0;
      cnt_exc  = 0;
   endtask

   // One cycle: drive both buses on the falling edge, then check the chosen
   // DUT's state and tally its one-shot enables.
   task automatic step(input string tag, input bit use_b, input logic [5:0] op,
                       input logic rdy, input logic [3:0] exp_state);
      @(negedge clk);
      bus_a.Opcode   = op;
      bus_a.MemReady = rdy;
      bus_b.Opcode   = op;
      bus_b.MemReady = rdy;
      #1;
      if (use_b) begin
         check(tag, 32'(bus_b.State), 32'(exp_state));
         cnt_regw += int'(bus_b.RegWrite);
         cnt_memw += int'(bus_b.MemWrite);
         cnt_exc  += int'(bus_b.ExcValid);
      end else begin
         check(tag, 32'(bus_a.State), 32'(exp_state));
         cnt_regw += int'(bus_a.RegWrite);
         cnt_memw += int'(bus_a.MemWrite);
         cnt_exc  += int'(bus_a.ExcValid);
      end
   endtask

   initial begin
      bus_a.Opcode   = 6'h00;
      bus_a.MemReady = 1'b1;
      bus_b.Opcode   = 6'h00;
      bus_b.MemReady = 1'b1;
      clear_counts();

      // Reset: everything low even with MemReady high.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst.outs", 32'(outs_a), 0);
      rst_n = 1'b1;
      #1;
      check("rel.state",   32'(bus_a.State), 0);
      check("rel.memread", 32'(bus_a.MemRead), 1);
      check("rel.irwrite", 32'(bus_a.IRWrite), 1);
      check("rel.pcwrite", 32'(bus_a.PCWrite), 1);
      check("rel.alusrcb", 32'(bus_a.ALUSrcB), 1);
      check("rel.memsize", 32'(bus_a.MemSize), 2);

      // R-type: 0,1,6,7,0.
      step("rt.dec", 0, 6'b000000, 1'b1, 4'd1);
      check("rt.dec.alusrcb", 32'(bus_a.ALUSrcB), 3);
      step("rt.exe", 0, 6'b000000, 1'b1, 4'd6);
      check("rt.exe.aluop", 32'(bus_a.ALUOp), 2);
      check("rt.exe.alusrca", 32'(bus_a.ALUSrcA), 1);
      step("rt.wb", 0, 6'b000000, 1'b1, 4'd7);
      check("rt.wb.regwrite", 32'(bus_a.RegWrite), 1);
      check("rt.wb.regdst", 32'(bus_a.RegDst), 1);
      step("rt.fetch", 0, 6'b000000, 1'b1, 4'd0);
      check("rt.regw_cnt", 32'(cnt_regw), 1);

      // lh with three wait cycles: 0,1,2,3,3,3,3,4,0.
      clear_counts();
      step("lh.dec", 0, 6'b100001, 1'b1, 4'd1);
      step("lh.addr", 0, 6'b100001, 1'b1, 4'd2);
      check("lh.addr.memsize", 32'(bus_a.MemSize), 1);
      check("lh.addr.alusrcb", 32'(bus_a.ALUSrcB), 2);
      for (int i = 0; i < 3; i++) begin
         step("lh.rd.wait", 0, 6'b100001, 1'b0, 4'd3);
         check("lh.rd.memsize", 32'(bus_a.MemSize), 1);
      end
      step("lh.rd.ready", 0, 6'b100001, 1'b1, 4'd3);
      check("lh.rd.iord", 32'(bus_a.IorD), 1);
      check("lh.rd.memread", 32'(bus_a.MemRead), 1);
      step("lh.wb", 0, 6'b100001, 1'b1, 4'd4);
      check("lh.wb.memtoreg", 32'(bus_a.MemtoReg), 1);
      check("lh.wb.regwrite", 32'(bus_a.RegWrite), 1);
      step("lh.fetch", 0, 6'b100001, 1'b1, 4'd0);
      check("lh.regw_cnt", 32'(cnt_regw), 1);

      // sb: 0,1,2,5,0 with a single byte-wide write.
      clear_counts();
      step("sb.dec", 0, 6'b101000, 1'b1, 4'd1);
      step("sb.addr", 0, 6'b101000, 1'b1, 4'd2);
      check("sb.addr.memsize", 32'(bus_a.MemSize), 0);
      step("sb.wr", 0, 6'b101000, 1'b1, 4'd5);
      check("sb.wr.memwrite", 32'(bus_a.MemWrite), 1);
      check("sb.wr.memsize", 32'(bus_a.MemSize), 0);
      check("sb.wr.iord", 32'(bus_a.IorD), 1);
      step("sb.fetch", 0, 6'b101000, 1'b1, 4'd0);
      check("sb.memw_cnt", 32'(cnt_memw), 1);
      check("sb.regw_cnt", 32'(cnt_regw), 0);

      // beq: 0,1,8,0.
      step("beq.dec", 0, 6'b000100, 1'b1, 4'd1);
      step("beq.br", 0, 6'b000100, 1'b1, 4'd8);
      check("beq.pcwritecond", 32'(bus_a.PCWriteCond), 1);
      check("beq.pcsource", 32'(bus_a.PCSource), 1);
      check("beq.aluop", 32'(bus_a.ALUOp), 1);
      step("beq.fetch", 0, 6'b000100, 1'b1, 4'd0);

      // j: 0,1,9,0.
      step("j.dec", 0, 6'b000010, 1'b1, 4'd1);
      step("j.jump", 0, 6'b000010, 1'b1, 4'd9);
      check("j.pcwrite", 32'(bus_a.PCWrite), 1);
      check("j.pcsource", 32'(bus_a.PCSource), 2);
      step("j.fetch", 0, 6'b000010, 1'b1, 4'd0);

      // ori: 0,1,10,11,0.
      clear_counts();
      step("ori.dec", 0, 6'b001101, 1'b1, 4'd1);
      step("ori.exec", 0, 6'b001101, 1'b1, 4'd10);
      check("ori.aluop", 32'(bus_a.ALUOp), 3);
      check("ori.alusrcb", 32'(bus_a.ALUSrcB), 2);
      step("ori.wb", 0, 6'b001101, 1'b1, 4'd11);
      check("ori.wb.regwrite", 32'(bus_a.RegWrite), 1);
      check("ori.wb.regdst", 32'(bus_a.RegDst), 0);
      step("ori.fetch", 0, 6'b001101, 1'b1, 4'd0);
      check("ori.regw_cnt", 32'(cnt_regw), 1);

      // Illegal opcode with traps enabled: 0,1,12,0.
      clear_counts();
      step("ill.dec", 0, 6'b111111, 1'b1, 4'd1);
      step("ill.trap", 0, 6'b111111, 1'b1, 4'd12);
      check("ill.excvalid", 32'(bus_a.ExcValid), 1);
      check("ill.exccause", 32'(bus_a.ExcCause), 1);
      check("ill.pcsource", 32'(bus_a.PCSource), 3);
      check("ill.pcwrite", 32'(bus_a.PCWrite), 1);
      // FETCH after the trap also starts the timeout run (first stalled cycle).
      step("ill.fetch", 0, 6'b000000, 1'b0, 4'd0);
      check("ill.cause_hold", 32'(bus_a.ExcCause), 1);
      check("ill.exc_cnt", 32'(cnt_exc), 1);

      // Timeout: five stalled FETCH cycles, then TRAP with cause 10.
      clear_counts();
      for (int i = 0; i < 4; i++) begin
         step("to.fetch.wait", 0, 6'b000000, 1'b0, 4'd0);
         check("to.fetch.pcwrite", 32'(bus_a.PCWrite), 0);
      end
      step("to.trap", 0, 6'b000000, 1'b0, 4'd12);
      check("to.exccause", 32'(bus_a.ExcCause), 2);
      check("to.excvalid", 32'(bus_a.ExcValid), 1);

      // Ready on the boundary cycle wins over the timeout.
      clear_counts();
      for (int i = 0; i < 4; i++) begin
         step("tob.fetch.wait", 0, 6'b000000, 1'b0, 4'd0);
      end
      step("tob.fetch.ready", 0, 6'b000000, 1'b1, 4'd0);
      check("tob.irwrite", 32'(bus_a.IRWrite), 1);
      step("tob.dec", 0, 6'b000000, 1'b1, 4'd1);
      check("tob.exc_cnt", 32'(cnt_exc), 0);
      step("tob.exe", 0, 6'b000000, 1'b1, 4'd6);
      step("tob.wb", 0, 6'b000000, 1'b1, 4'd7);
      step("tob.fetch", 0, 6'b000000, 1'b1, 4'd0);

      // sw stalled in MEMWRITE, then reset mid-wait.
      clear_counts();
      step("sw.dec", 0, 6'b101011, 1'b1, 4'd1);
      step("sw.addr", 0, 6'b101011, 1'b1, 4'd2);
      check("sw.addr.memsize", 32'(bus_a.MemSize), 2);
      step("sw.wr0", 0, 6'b101011, 1'b0, 4'd5);
      check("sw.wr0.memwrite", 32'(bus_a.MemWrite), 1);
      step("sw.wr1", 0, 6'b101011, 1'b0, 4'd5);
      check("sw.wr1.memwrite", 32'(bus_a.MemWrite), 1);
      check("sw.cause_before", 32'(bus_a.ExcCause), 2);
      rst_n = 1'b0;
      #1;
      check("swrst.memwrite", 32'(bus_a.MemWrite), 0);
      check("swrst.outs", 32'(outs_a), 0);
      @(negedge clk);
      bus_a.MemReady = 1'b0;
      bus_b.MemReady = 1'b0;
      rst_n = 1'b1;
      #1;
      check("swrst.state", 32'(bus_a.State), 0);
      check("swrst.exccause", 32'(bus_a.ExcCause), 0);
      check("swrst.memread", 32'(bus_a.MemRead), 1);
      check("swrst.irwrite", 32'(bus_a.IRWrite), 0);

      // Illegal opcode with traps disabled: 0,1,0 and no pulse.
      clear_counts();
      step("nx.fetch", 1, 6'b111111, 1'b1, 4'd0);
      step("nx.dec", 1, 6'b111111, 1'b1, 4'd1);
      step("nx.fetch2", 1, 6'b111111, 1'b1, 4'd0);
      check("nx.exc_cnt", 32'(cnt_exc), 0);
      check("nx.exccause", 32'(bus_b.ExcCause), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
